// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch unit: owns fetch PC, issues imem reads, hands {inst, pc, pc+4} downstream
// Single outstanding request; redirects win over everything and stale responses are discarded.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_next
);

  typedef enum logic [1:0] {REQ, WAIT, VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        discard_q, discard_d;
  logic        req;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    discard_d = discard_q;
    req       = 1'b0;

    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        WAIT: begin
          // A response landing with the redirect is the stale one; otherwise remember to drop it.
          if (imem_resp) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          req     = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_resp) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else begin
              inst_d    = imem_rdata;
              inst_pc_d = pc_q;
              pc_d      = pc_q + 32'd4;
              state_d   = VALID;
            end
          end
        end
        VALID: begin
          if (inst_ready) begin
            req     = 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_resp) begin
      assert (state_q == WAIT);
    end
  end

  assign imem_addr    = pc_q;
  assign imem_rmask   = (req && !rst) ? 4'hf : 4'h0;
  assign inst_valid   = (state_q == VALID);
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_pc_next = inst_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
// Reference: expected delivered-PC and request-PC streams plus a latency-programmable memory.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_next;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc_next(inst_pc_next)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          rst_drv = 1'b1;
  bit          ready_drv = 1'b1;
  bit          redir_drv = 1'b0;
  logic [31:0] redir_pc_drv = 32'h0;
  int          lat = 1;

  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] req_pc = RESET_PC;
  bit          prev_redirect = 1'b0;

  bit          obs_req;
  logic [31:0] obs_addr;
  bit          obs_xfer;
  logic [31:0] last_pc, last_next;
  int          delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a3c96e1;
  endfunction

  // One clock: memory model, input drive, then checks against the expected streams.
  task automatic cycle();
    @(negedge clk);
    rst        = rst_drv;
    imem_resp  = 1'b0;
    imem_rdata = 32'hdeadbeef;
    if (rst_drv) begin
      mem_cnt = 0;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(mem_addr);
      end
    end
    inst_ready     = ready_drv;
    redirect_valid = redir_drv;
    redirect_pc    = redir_pc_drv;
    #1;
    obs_req  = (imem_rmask == 4'hf);
    obs_addr = imem_addr;
    obs_xfer = 1'b0;
    if (rst_drv) begin
      tests++;
      if (imem_rmask !== 4'h0) begin
        fails++; $display("FAIL rmask_in_reset: got %h want 0", imem_rmask);
      end
      exp_pc = RESET_PC; req_pc = RESET_PC; prev_redirect = 1'b0;
    end else begin
      tests++;
      if (imem_rmask !== 4'hf && imem_rmask !== 4'h0) begin
        fails++; $display("FAIL rmask_value: got %h want 0 or f", imem_rmask);
      end
      if (prev_redirect) begin
        tests++;
        if (inst_valid !== 1'b0) begin
          fails++; $display("FAIL valid_after_redirect: got %b want 0", inst_valid);
        end
      end
      if (obs_req) begin
        tests++;
        if (mem_cnt > 0 || imem_resp) begin
          fails++; $display("FAIL outstanding: got second request want none");
        end
        tests++;
        if (imem_addr !== req_pc) begin
          fails++; $display("FAIL req_addr: got %h want %h", imem_addr, req_pc);
        end
        req_pc   = req_pc + 32'd4;
        mem_cnt  = lat;
        mem_addr = imem_addr;
      end
      if (inst_valid === 1'b1 && inst_ready && !redirect_valid) begin
        tests++;
        if (inst_pc !== exp_pc) begin
          fails++; $display("FAIL inst_pc: got %h want %h", inst_pc, exp_pc);
        end
        tests++;
        if (inst !== mem_word(exp_pc)) begin
          fails++; $display("FAIL inst: got %h want %h", inst, mem_word(exp_pc));
        end
        tests++;
        if (inst_pc_next !== exp_pc + 32'd4) begin
          fails++; $display("FAIL inst_pc_next: got %h want %h", inst_pc_next, exp_pc + 32'd4);
        end
        last_pc   = inst_pc;
        last_next = inst_pc_next;
        exp_pc    = exp_pc + 32'd4;
        delivered++;
        obs_xfer  = 1'b1;
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        req_pc = exp_pc;
      end
      prev_redirect = redirect_valid;
    end
    redir_drv = 1'b0;
  endtask

  task automatic run_until_delivery(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      cycle();
      got = obs_xfer;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no delivery want one within 60 cycles", name);
    end
  endtask

  task automatic run_until_req(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      cycle();
      got = obs_req;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no request want one within 60 cycles", name);
    end
  endtask

  task automatic run_until_valid(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      cycle();
      got = (inst_valid === 1'b1);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no inst_valid want one within 60 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_drv = 1'b1; ready_drv = 1'b1; lat = 1;
    cycle(); cycle();
    rst_drv = 1'b0;
    cycle();
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", inst_valid);
    end
    tests++;
    if (!obs_req || obs_addr !== RESET_PC) begin
      fails++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", obs_req, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 6; i++) begin
      cycle();
      tests++;
      if (obs_xfer !== (i % 2 == 0)) begin
        fails++; $display("FAIL stream_cadence: cycle %0d got xfer=%b want %b", i, obs_xfer, (i % 2 == 0));
      end
      if (obs_xfer) begin
        tests++;
        if (last_pc !== RESET_PC + 32'(4 * (i / 2 - 1))) begin
          fails++; $display("FAIL stream_pc: got %h want %h", last_pc, RESET_PC + 32'(4 * (i / 2 - 1)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_inst, hold_pc;
    ready_drv = 1'b0;
    run_until_valid("bp");
    hold_inst = inst; hold_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      tests++;
      if (inst_valid !== 1'b1 || inst !== hold_inst || inst_pc !== hold_pc) begin
        fails++; $display("FAIL bp_hold: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h", inst_valid, inst, inst_pc, hold_inst, hold_pc);
      end
      tests++;
      if (obs_req) begin
        fails++; $display("FAIL bp_no_req: got rmask=%h want 0", imem_rmask);
      end
    end
    ready_drv = 1'b1;
    cycle();
    tests++;
    if (!obs_xfer || !obs_req) begin
      fails++; $display("FAIL bp_release: got xfer=%b req=%b want 1 1", obs_xfer, obs_req);
    end
  endtask

  task automatic test_redirect_wait();
    ready_drv = 1'b1; lat = 3;
    run_until_req("rw");
    redir_drv = 1'b1; redir_pc_drv = 32'h1eceb100;
    cycle();
    run_until_delivery("rw");
    tests++;
    if (last_pc !== 32'h1eceb100) begin
      fails++; $display("FAIL rw_target: got %h want 1eceb100", last_pc);
    end
    lat = 1;
  endtask

  task automatic test_redirect_resp();
    ready_drv = 1'b1; lat = 1;
    run_until_req("rr");
    redir_drv = 1'b1; redir_pc_drv = 32'h1eceb200;
    cycle();
    tests++;
    if (!imem_resp || obs_req) begin
      fails++; $display("FAIL rr_same_cycle: got resp=%b req=%b want 1 0", imem_resp, obs_req);
    end
    cycle();
    tests++;
    if (!obs_req || obs_addr !== 32'h1eceb200) begin
      fails++; $display("FAIL rr_next_req: got req=%b addr=%h want 1 1eceb200", obs_req, obs_addr);
    end
    run_until_delivery("rr");
    run_until_delivery("rr");
    tests++;
    if (last_pc !== 32'h1eceb204) begin
      fails++; $display("FAIL rr_second: got %h want 1eceb204", last_pc);
    end
  endtask

  task automatic test_redirect_valid();
    ready_drv = 1'b0; lat = 1;
    run_until_valid("rv");
    ready_drv = 1'b1; redir_drv = 1'b1; redir_pc_drv = 32'h1eceb102;
    cycle();
    tests++;
    if (obs_req || obs_xfer) begin
      fails++; $display("FAIL rv_no_req: got req=%b xfer=%b want 0 0", obs_req, obs_xfer);
    end
    run_until_delivery("rv");
    tests++;
    if (last_pc !== 32'h1eceb100) begin
      fails++; $display("FAIL rv_target: got %h want 1eceb100", last_pc);
    end
  endtask

  task automatic test_wrap();
    ready_drv = 1'b1; lat = 1;
    redir_drv = 1'b1; redir_pc_drv = 32'hfffffffc;
    cycle();
    run_until_delivery("wrap");
    tests++;
    if (last_pc !== 32'hfffffffc || last_next !== 32'h0) begin
      fails++; $display("FAIL wrap_pc: got pc=%h next=%h want fffffffc 00000000", last_pc, last_next);
    end
    tests++;
    if (!obs_req || obs_addr !== 32'h0) begin
      fails++; $display("FAIL wrap_req: got req=%b addr=%h want 1 00000000", obs_req, obs_addr);
    end
  endtask

  task automatic test_random();
    int start = delivered;
    for (int i = 0; i < 1500; i++) begin
      ready_drv = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        redir_drv = 1'b1;
        redir_pc_drv = ($urandom_range(0, 3) == 0) ? 32'hfffffff0 + $urandom_range(0, 15)
                                                   : RESET_PC + $urandom_range(0, 1023);
      end
      cycle();
    end
    tests++;
    if (delivered - start < 100) begin
      fails++; $display("FAIL random_progress: got %0d deliveries want >= 100", delivered - start);
    end
  endtask

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_valid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1000000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch unit; the producer side of the decode interface.
- Owns the architectural fetch PC and issues single-beat read requests to the instruction memory port.
- Captures each returned word and presents {inst, pc, pc+4} to id_stage / the instruction queue over a valid/ready handshake.
- Accepts redirects from the backend (branch/jump resolution, flush) and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h1eceb000, PC fetched after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  32  fetch address, word aligned.
- imem_rmask  out  4  4'hf for one cycle = issue request; 4'h0 otherwise.
- imem_rdata  in  32  returned instruction word, valid only with imem_resp.
- imem_resp  in  1  one-cycle response strobe for the single outstanding request.
- redirect_valid  in  1  backend redirect/flush this cycle.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  inst/inst_pc/inst_pc_next are valid.
- inst_ready  in  1  downstream (instruction queue) can accept.
- inst  out  32  fetched instruction word (feeds id_stage imem_rdata).
- inst_pc  out  32  PC of inst (feeds id_stage pc_curr).
- inst_pc_next  out  32  inst_pc + 4, mod 2^32.

Behaviour:
- State machine with states REQ, WAIT, VALID. Registers:
  - pc_q: next PC to fetch.
  - inst_q, inst_pc_q: captured word and its PC.
  - discard_q: 1 = drop the next response.
- Reset (rst high at a clock edge): state=REQ, pc_q=RESET_PC, discard_q=0, inst_valid=0. imem_rmask is 0 during the reset cycle. inst, inst_pc and inst_pc_next are don't-care while inst_valid=0.
- Request rule:
  - imem_rmask=4'hf and imem_addr=pc_q when !redirect_valid and either state==REQ, or state==VALID and inst_ready.
  - Otherwise imem_rmask=0 and imem_addr=pc_q.
  - Each request is a one-cycle pulse. Never more than one outstanding request.
- REQ: an issued request moves to WAIT. If redirect_valid: pc_q<=redirect_pc, stay in REQ, no request that cycle.
- WAIT:
  - On imem_resp with discard_q=0: inst_q<=imem_rdata, inst_pc_q<=pc_q, pc_q<=pc_q+4, go to VALID. Response-to-inst_valid latency is 1 cycle.
  - On imem_resp with discard_q=1: drop the word, discard_q<=0, go to REQ.
  - If no response arrives, stay in WAIT indefinitely; there is no timeout.
- VALID:
  - inst_valid=1; inst=inst_q, inst_pc=inst_pc_q, inst_pc_next=inst_pc_q+4.
  - If inst_ready: transfer completes and the next request issues the same cycle, go to WAIT.
  - If !inst_ready: hold all outputs stable and stay in VALID; no request.
- Throughput with 1-cycle memory and inst_ready held high: one instruction every 2 cycles.
- Redirect (highest priority, any state):
  - pc_q<={redirect_pc[31:2],2'b00}; inst_valid deasserts the next cycle.
  - A VALID instruction is dropped, even if inst_ready is high the same cycle; the consumer must ignore it because the flush wins.
  - WAIT with no imem_resp this cycle: discard_q<=1, stay in WAIT.
  - WAIT with imem_resp this cycle: drop the word, go to REQ; discard_q unchanged at 0.
  - WAIT with discard_q already 1: update pc_q only; exactly one stale response is still dropped.
  - After a redirect, the first request to the new PC issues no earlier than the cycle after the redirect.
- Arithmetic: all PC increments are 32-bit and wrap (32'hfffffffc+4 = 0). inst_pc_next wraps the same way.
- rst while in WAIT: returns to REQ with discard_q=0. The memory side is reset together, so no stale response is expected.
- imem_resp outside WAIT is illegal; assert in simulation, ignore in RTL.

Test Plan:
- Reset, memory 1-cycle latency, inst_ready=1 → first request addr 1eceb000 the cycle after reset deasserts; inst_pc sequence 1eceb000, 1eceb004, 1eceb008 on every other cycle; inst_pc_next = inst_pc+4.
- Backpressure: inst_ready=0 for 5 cycles while VALID → inst, inst_pc stable and imem_rmask=0 throughout; on release, transfer and a new request occur in the same cycle.
- Redirect to 32'h1eceb100 while WAIT with 3-cycle memory latency → stale response dropped, inst_valid stays 0, next request addr 1eceb100, delivered inst_pc=1eceb100.
- Redirect in the same cycle as imem_resp → word dropped, state REQ, next request to the redirect target; no extra word dropped later.
- Redirect while VALID with inst_ready=1 → no request that cycle, inst_valid=0 next cycle; redirect_pc=32'h1eceb102 fetches 1eceb100.
- Wrap: redirect to 32'hfffffffc → inst_pc=fffffffc, inst_pc_next=0, following fetch addr 0.
